// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared definitions for the nibble-serial multiplier sequencer.
//   state_t  - controller state encoding (IDLE, CALC, DONE)
//   NIB      - width of one operand slice fed to the shared 4x4 multiplier
//   steps()  - number of partial products needed for a WIDTH x WIDTH multiply
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    function automatic int steps(input int width);
        return (width / NIB) * (width / NIB);
    endfunction

endpackage

// File: rtl/mul_4x4.sv
// mul_4x4: purely combinational 4-bit x 4-bit unsigned multiplier.
//   in_a  in  4  multiplicand nibble
//   in_b  in  4  multiplier nibble
//   out   out 8  in_a * in_b
module mul_4x4 (
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [7:0] out
);

    assign out = in_a * in_b;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: WIDTH x WIDTH unsigned multiplier built around a single shared
// mul_4x4. One nibble pair is multiplied per cycle and the shifted partial
// product is added into a 2*WIDTH accumulator.
//   clk        in   1        clock
//   rst        in   1        synchronous active-high reset
//   in_a       in   WIDTH    multiplicand, captured on accept
//   in_b       in   WIDTH    multiplier, captured on accept
//   in_valid   in   1        operand pair offered
//   out_ready  out  1        idle and able to accept (accept = in_valid & out_ready)
//   out_prod   out  2*WIDTH  accumulator / final product
//   out_valid  out  1        out_prod holds a finished product
//   in_ready   in   1        consumer takes the product (handoff = out_valid & in_ready)
//   out_busy   out  1        multiply in progress
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_valid,
    output logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_valid,
    input  logic                 in_ready,
    output logic                 out_busy
);

    localparam int unsigned N      = WIDTH / NIB;
    localparam int          STEPS  = steps(WIDTH);
    localparam int          STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;

    int unsigned           idx_i, idx_j;
    logic [NIB-1:0]        nib_a, nib_b;
    logic [7:0]            pp;
    logic [2*WIDTH-1:0]    pp_shift;

    // Nibble selection: step walks i (a slice) slow and j (b slice) fast.
    always_comb begin
        idx_i = 32'(step_q) / N;
        idx_j = 32'(step_q) % N;
        nib_a = NIB'(a_q >> (NIB * idx_i));
        nib_b = NIB'(b_q >> (NIB * idx_j));
    end

    mul_4x4 u_mul (
        .in_a (nib_a),
        .in_b (nib_b),
        .out  (pp)
    );

    // Partial product is zero-extended to the accumulator width before shifting.
    always_comb begin
        pp_shift = (2*WIDTH)'(pp) << (NIB * (idx_i + idx_j));
    end

    // Controller next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp_shift;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (in_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register stage: control and accumulator are reset, operand latches are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign out_ready = (state_q == IDLE);
    assign out_busy  = (state_q == CALC);
    assign out_valid = (state_q == DONE);
    assign out_prod  = acc_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: self-checking bench for mul_seq_ctrl at WIDTH = 8, 4 and 16.
// Expected products come from plain a*b arithmetic; ordering and latency from
// queues of accepted transactions.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  a8, b8;
    logic        iv8, ir8, or8, ov8, ob8;
    logic [15:0] p8;

    logic [3:0]  a4, b4;
    logic        iv4, ir4, or4, ov4, ob4;
    logic [7:0]  p4;

    logic [15:0] a16, b16;
    logic        iv16, ir16, or16, ov16, ob16;
    logic [31:0] p32;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_a(a8), .in_b(b8), .in_valid(iv8),
        .out_ready(or8), .out_prod(p8), .out_valid(ov8), .in_ready(ir8), .out_busy(ob8)
    );

    mul_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_a(a4), .in_b(b4), .in_valid(iv4),
        .out_ready(or4), .out_prod(p4), .out_valid(ov4), .in_ready(ir4), .out_busy(ob4)
    );

    mul_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_a(a16), .in_b(b16), .in_valid(iv16),
        .out_ready(or16), .out_prod(p32), .out_valid(ov16), .in_ready(ir16), .out_busy(ob16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv8 = 1'b0; ir8 = 1'b0; a8 = '0; b8 = '0;
        iv4 = 1'b0; ir4 = 1'b0; a4 = '0; b4 = '0;
        iv16 = 1'b0; ir16 = 1'b0; a16 = '0; b16 = '0;
        tick;
        tick;
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL reset_out_ready: got %b expected 1", or8); end
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
        n_checks++; if (ob8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_busy: got %b expected 0", ob8); end
        n_checks++; if (p8 !== 16'h0000) begin n_fail++; $display("FAIL reset_out_prod: got %h expected 0000", p8); end
        rst = 1'b0;
        tick;
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: out_ready got %b expected 1", or8); end
    endtask

    task automatic test_max;
        int lat;
        bit busy_ok;
        ir8 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (ov8 !== 1'b1 && lat < 40) begin
            if (ob8 !== 1'b1 || or8 !== 1'b0) busy_ok = 1'b0;
            tick;
            lat++;
        end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL max_latency: got %0d expected 4", lat); end
        n_checks++; if (p8 !== 16'hFE01) begin n_fail++; $display("FAIL max_product: got %h expected fe01", p8); end
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL max_busy_during_calc: got %b expected 1", busy_ok); end
        n_checks++; if (ob8 !== 1'b0 || or8 !== 1'b0) begin n_fail++; $display("FAIL max_done_flags: busy %b ready %b expected 0 0", ob8, or8); end
        tick;
        ir8 = 1'b0;
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL max_valid_drop: got %b expected 0", ov8); end
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL max_ready_after_handoff: got %b expected 1", or8); end
    endtask

    task automatic test_backpressure;
        int lat;
        ir8 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin tick; lat++; end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        n_checks++; if (p8 !== 16'h03A8) begin n_fail++; $display("FAIL bp_product: got %h expected 03a8", p8); end
        for (int k = 0; k < 10; k++) begin
            tick;
            n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, ov8); end
            n_checks++; if (p8 !== 16'h03A8) begin n_fail++; $display("FAIL bp_hold_prod[%0d]: got %h expected 03a8", k, p8); end
        end
        ir8 = 1'b1;
        tick;
        ir8 = 1'b0;
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", ov8); end
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b expected 1", or8); end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate[%0d]: got %b expected 0", k, ov8); end
        end
    endtask

    task automatic test_ignore_inputs;
        int lat;
        bit ready_ok;
        ir8 = 1'b1;
        a8 = 8'hA5; b8 = 8'h3C; iv8 = 1'b1;
        tick;
        lat = 0; ready_ok = 1'b1;
        while (ov8 !== 1'b1 && lat < 40) begin
            if (or8 !== 1'b0) ready_ok = 1'b0;
            iv8 = ~iv8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick;
            lat++;
        end
        ir8 = 1'b0;
        iv8 = 1'b0;
        n_checks++; if (ready_ok !== 1'b1) begin n_fail++; $display("FAIL ign_ready_low: got %b expected 1", ready_ok); end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ign_latency: got %0d expected 4", lat); end
        n_checks++; if (p8 !== 16'h26AC) begin n_fail++; $display("FAIL ign_product: got %h expected 26ac", p8); end
        ir8 = 1'b1;
        tick;
        ir8 = 1'b0;
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL ign_back_idle: got %b expected 1", or8); end
    endtask

    task automatic test_mid_reset;
        int lat;
        ir8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        tick;
        n_checks++; if (ob8 !== 1'b1) begin n_fail++; $display("FAIL mr_busy_before_reset: got %b expected 1", ob8); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (or8 !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b expected 1", or8); end
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b expected 0", ov8); end
        n_checks++; if (ob8 !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %b expected 0", ob8); end
        n_checks++; if (p8 !== 16'h0000) begin n_fail++; $display("FAIL mr_acc: got %h expected 0000", p8); end
        for (int k = 0; k < 6; k++) begin
            tick;
            n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mr_discarded[%0d]: got %b expected 0", k, ov8); end
        end
        rst = 1'b1; a8 = 8'h03; b8 = 8'h03; iv8 = 1'b1;
        tick;
        rst = 1'b0; iv8 = 1'b0;
        tick;
        n_checks++; if (ob8 !== 1'b0 || or8 !== 1'b1) begin n_fail++; $display("FAIL mr_reset_wins: busy %b ready %b expected 0 1", ob8, or8); end
        a8 = 8'h07; b8 = 8'h09; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin tick; lat++; end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL mr_next_latency: got %0d expected 4", lat); end
        n_checks++; if (p8 !== 16'h003F) begin n_fail++; $display("FAIL mr_next_product: got %h expected 003f", p8); end
        ir8 = 1'b1;
        tick;
        ir8 = 1'b0;
    endtask

    task automatic test_random;
        localparam int NTX = 1500;
        logic [15:0] exp_q[$];
        int          acc_cyc_q[$];
        logic [15:0] e;
        int sent, got, cyc, r;
        bit prev_v, accepted;
        sent = 0; got = 0; cyc = 0; prev_v = 1'b0;
        ir8 = 1'b0; iv8 = 1'b0;
        while (got < NTX && cyc < 60000) begin
            if (ov8 === 1'b1 && !prev_v) begin
                n_checks++;
                if (acc_cyc_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_latency: valid with no accepted operands, expected none");
                end else if (cyc - acc_cyc_q[0] != 4) begin
                    n_fail++; $display("FAIL rnd_latency: got %0d expected 4", cyc - acc_cyc_q[0]);
                end
            end
            prev_v = ov8;
            ir8 = ($urandom_range(0, 2) != 0);
            if (ov8 === 1'b1 && ir8) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra_result: got %h expected nothing", p8);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_cyc_q.pop_front());
                    if (p8 !== e) begin n_fail++; $display("FAIL rnd_product[%0d]: got %h expected %h", got, p8, e); end
                end
                got++;
            end
            if (!iv8 && sent < NTX && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 7);
                a8 = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
                r = $urandom_range(0, 7);
                b8 = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
                iv8 = 1'b1;
            end
            accepted = 1'b0;
            if (iv8 && or8 === 1'b1) begin
                exp_q.push_back(16'(a8) * 16'(b8));
                acc_cyc_q.push_back(cyc + 1);
                sent++;
                accepted = 1'b1;
            end
            tick;
            cyc++;
            if (accepted) iv8 = 1'b0;
        end
        iv8 = 1'b0;
        n_checks++; if (got != NTX) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", got, NTX); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d expected 0", exp_q.size()); end
        ir8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL rnd_no_duplicate[%0d]: got %b expected 0", k, ov8); end
        end
        ir8 = 1'b0;
    endtask

    task automatic test_width4;
        int lat;
        logic [7:0] e;
        ir4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a4 = (k == 0) ? 4'hF : 4'($urandom);
            b4 = (k == 0) ? 4'hF : 4'($urandom);
            e = 8'(a4) * 8'(b4);
            iv4 = 1'b1;
            tick;
            iv4 = 1'b0;
            lat = 0;
            while (ov4 !== 1'b1 && lat < 20) begin tick; lat++; end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL w4_latency[%0d]: got %0d expected 1", k, lat); end
            n_checks++; if (p4 !== e) begin n_fail++; $display("FAIL w4_product[%0d]: got %h expected %h", k, p4, e); end
            tick;
            n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL w4_valid_drop[%0d]: got %b expected 0", k, ov4); end
        end
        ir4 = 1'b0;
    endtask

    task automatic test_width16;
        int lat;
        logic [31:0] e;
        ir16 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a16 = (k == 0) ? 16'hFFFF : 16'($urandom);
            b16 = (k == 0) ? 16'hFFFF : 16'($urandom);
            e = 32'(a16) * 32'(b16);
            iv16 = 1'b1;
            tick;
            iv16 = 1'b0;
            lat = 0;
            while (ov16 !== 1'b1 && lat < 60) begin tick; lat++; end
            n_checks++; if (lat != 16) begin n_fail++; $display("FAIL w16_latency[%0d]: got %0d expected 16", k, lat); end
            n_checks++; if (p32 !== e) begin n_fail++; $display("FAIL w16_product[%0d]: got %h expected %h", k, p32, e); end
            tick;
        end
        ir16 = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_max;
        test_backpressure;
        test_ignore_inputs;
        test_mid_reset;
        test_random;
        test_width4;
        test_width16;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
